// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding, frame constants and parity helper
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam int   DATA_BITS   = 8;
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - small synchronous byte FIFO in front of the UART transmitter
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge sys_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at a power-of-two depth; count tracks simultaneous push/pop.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter (start, 8 data MSB first, even parity, stop); optional input FIFO via UART_TX_FIFO_EN
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       TX,
    output logic       busy
);

    localparam int                CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

    uart_state_t          state_q, state_d;
    logic [CNT_W-1:0]     baud_q, baud_d;
    logic [2:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 load;
    logic                 baud_last;
    logic                 src_valid;
    logic [DATA_BITS-1:0] src_data;

`ifdef UART_TX_FIFO_EN
    logic                 fifo_empty;
    logic                 fifo_full;
    logic [DATA_BITS-1:0] fifo_rd_data;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .sys_clk (sys_clk),
        .rst     (rst),
        .push    (tx_valid),
        .wr_data (tx_data),
        .pop     (load),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    assign tx_ready  = !fifo_full;
    assign src_valid = !fifo_empty;
    assign src_data  = fifo_rd_data;
`else
    assign tx_ready  = (state_q == IDLE) && !rst;
    assign src_valid = tx_valid;
    assign src_data  = tx_data;
`endif

    assign TX        = tx_q;
    assign busy      = (state_q != IDLE);
    assign baud_last = (baud_q == BAUD_LAST);

    // Next-state, baud/bit counters, shifter and registered line level.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        load    = 1'b0;

        if (state_q != IDLE) begin
            baud_d = baud_last ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                tx_d = IDLE_LEVEL;
                if (src_valid) begin
                    load    = 1'b1;
                    shift_d = src_data;
                    par_d   = even_parity(src_data);
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = START_LEVEL;
                    state_d = START;
                end
            end
            START: begin
                if (baud_last) begin
                    tx_d    = shift_q[DATA_BITS-1];
                    shift_d = {shift_q[DATA_BITS-2:0], 1'b0};
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_last) begin
                    if (bit_q == DATA_LAST) begin
                        tx_d    = par_q;
                        state_d = PARITY;
                    end else begin
                        tx_d    = shift_q[DATA_BITS-1];
                        shift_d = {shift_q[DATA_BITS-2:0], 1'b0};
                        bit_d   = bit_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (baud_last) begin
                    tx_d    = IDLE_LEVEL;
                    bit_d   = '0;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (baud_last) begin
                    if (bit_q == STOP_LAST) begin
                        bit_d   = '0;
                        state_d = IDLE;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                tx_d    = IDLE_LEVEL;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset forces the line idle immediately.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= IDLE_LEVEL;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

endmodule
